// File: rtl/lwdf_sample_framer.sv
// Byte-to-sample framer for the LWDF filter input: synchronizes slow pin strobes,
// assembles little-endian DATA_W-bit samples and buffers them in a FWFT FIFO.
module lwdf_sample_framer #(
    parameter int DATA_W     = 16,
    parameter int FIFO_DEPTH = 4,
    localparam int BYTES     = DATA_W / 8,
    localparam int PH_W      = (BYTES > 1) ? $clog2(BYTES) : 1,
    localparam int AW        = $clog2(FIFO_DEPTH),
    localparam int LW        = AW + 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [7:0]        byte_in,
    input  logic              byte_strobe,
    input  logic              byte_sync,
    input  logic              clr_ovf,
    output logic [DATA_W-1:0] sample_data,
    output logic              sample_valid,
    input  logic              sample_ready,
    output logic [LW-1:0]     fifo_level,
    output logic              overflow,
    output logic [PH_W-1:0]   byte_phase
);

    localparam logic [PH_W-1:0] LAST_LANE = PH_W'(BYTES - 1);
    localparam logic [LW-1:0]   FULL_LVL  = LW'(FIFO_DEPTH);

    logic              strb_s1_q, strb_s2_q, strb_s3_q;
    logic              sync_s1_q, sync_s2_q;
    logic [7:0]        byte_s1_q, byte_s2_q;
    logic              cap_q, cap_sync_q;
    logic [7:0]        cap_byte_q;

    logic [PH_W-1:0]   phase_q, phase_d, lane;
    logic [DATA_W-1:0] partial_q, partial_d, word_d;
    logic              last_lane, push;

    logic [DATA_W-1:0] mem_q [FIFO_DEPTH];
    logic [AW-1:0]     wr_ptr_q, rd_ptr_q;
    logic [LW-1:0]     level_q, level_d;
    logic              ovf_q, full, pop, wr_en, drop;

    // Lane selection and word assembly for the byte captured this cycle.
    // NOTE: every always_comb output gets a default first so no latch is inferred.
    always_comb begin
        lane      = cap_sync_q ? '0 : phase_q;
        word_d    = cap_sync_q ? '0 : partial_q;
        for (int i = 0; i < BYTES; i++) begin
            if (lane == PH_W'(i)) word_d[i*8 +: 8] = cap_byte_q;
        end
        last_lane = (lane == LAST_LANE);
        push      = cap_q & last_lane;
        phase_d   = phase_q;
        partial_d = partial_q;
        if (cap_q) begin
            partial_d = word_d;
            phase_d   = last_lane ? '0 : lane + 1'b1;
        end
    end

    assign full  = (level_q == FULL_LVL);
    assign pop   = sample_valid & sample_ready;
    // A full FIFO still accepts the word when the head leaves on the same edge.
    assign wr_en = push & (~full | pop);
    assign drop  = push & full & ~pop;

    always_comb begin
        level_d = level_q;
        case ({wr_en, pop})
            2'b10:   level_d = level_q + 1'b1;
            2'b01:   level_d = level_q - 1'b1;
            default: level_d = level_q;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so every flop sees pre-edge values.
    always_ff @(posedge clk) begin
        if (rst) begin
            strb_s1_q  <= 1'b0;
            strb_s2_q  <= 1'b0;
            strb_s3_q  <= 1'b0;
            sync_s1_q  <= 1'b0;
            sync_s2_q  <= 1'b0;
            byte_s1_q  <= '0;
            byte_s2_q  <= '0;
            cap_q      <= 1'b0;
            cap_sync_q <= 1'b0;
            cap_byte_q <= '0;
            phase_q    <= '0;
            partial_q  <= '0;
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            level_q    <= '0;
            ovf_q      <= 1'b0;
        end else begin
            strb_s1_q  <= byte_strobe;
            strb_s2_q  <= strb_s1_q;
            strb_s3_q  <= strb_s2_q;
            sync_s1_q  <= byte_sync;
            sync_s2_q  <= sync_s1_q;
            byte_s1_q  <= byte_in;
            byte_s2_q  <= byte_s1_q;
            // The rising edge is registered together with its byte; capture is one edge later.
            cap_q      <= strb_s2_q & ~strb_s3_q;
            cap_sync_q <= sync_s2_q;
            cap_byte_q <= byte_s2_q;
            phase_q    <= phase_d;
            partial_q  <= partial_d;
            level_q    <= level_d;
            if (wr_en) wr_ptr_q <= wr_ptr_q + 1'b1;
            if (pop)   rd_ptr_q <= rd_ptr_q + 1'b1;
            if (drop)         ovf_q <= 1'b1;
            else if (clr_ovf) ovf_q <= 1'b0;
        end
    end

    // NOTE: the sample storage has no reset; empty entries are never observable.
    always_ff @(posedge clk) begin
        if (wr_en) mem_q[wr_ptr_q] <= word_d;
    end

    assign sample_valid = (level_q != '0);
    assign sample_data  = sample_valid ? mem_q[rd_ptr_q] : '0;
    assign fifo_level   = level_q;
    assign overflow     = ovf_q;
    assign byte_phase   = phase_q;

endmodule

// File: tb/tb_lwdf_sample_framer.sv
// Directed bench for lwdf_sample_framer: framing, resync, backpressure, overflow and reset.
module tb_lwdf_sample_framer;

    logic        clk = 1'b0;
    logic        rst;
    logic [7:0]  byte_in;
    logic        byte_strobe, byte_sync, clr_ovf, sample_ready;
    logic [15:0] sample_data;
    logic        sample_valid, overflow;
    logic [2:0]  fifo_level;
    logic [0:0]  byte_phase;

    int n_vec = 0;
    int n_bad = 0;

    lwdf_sample_framer #(.DATA_W(16), .FIFO_DEPTH(4)) dut (
        .clk          (clk),
        .rst          (rst),
        .byte_in      (byte_in),
        .byte_strobe  (byte_strobe),
        .byte_sync    (byte_sync),
        .clr_ovf      (clr_ovf),
        .sample_data  (sample_data),
        .sample_valid (sample_valid),
        .sample_ready (sample_ready),
        .fifo_level   (fifo_level),
        .overflow     (overflow),
        .byte_phase   (byte_phase)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Pin-level byte transfer with 3-cycle setup/hold around the strobe rise.
    task automatic send_byte(input logic [7:0] b, input logic s, input int hi_cycles);
        byte_in   = b;
        byte_sync = s;
        repeat (3) @(negedge clk);
        byte_strobe = 1'b1;
        repeat (hi_cycles) @(negedge clk);
        byte_strobe = 1'b0;
        repeat (3) @(negedge clk);
    endtask

    task automatic send_word(input logic [15:0] w);
        send_byte(w[7:0], 1'b1, 4);
        send_byte(w[15:8], 1'b0, 4);
    endtask

    task automatic pop_one();
        sample_ready = 1'b1;
        @(negedge clk);
        sample_ready = 1'b0;
    endtask

    initial begin
        rst = 1'b1; byte_in = '0; byte_strobe = 1'b0; byte_sync = 1'b0;
        clr_ovf = 1'b0; sample_ready = 1'b0;
        repeat (2) @(negedge clk);
        check("rst_valid", sample_valid, 0);
        check("rst_data", sample_data, 0);
        check("rst_level", fifo_level, 0);
        check("rst_phase", byte_phase, 0);
        check("rst_ovf", overflow, 0);
        rst = 1'b0;
        @(negedge clk);

        // Basic framing with ready held high, including the 4-edge latency.
        sample_ready = 1'b1;
        send_byte(8'h34, 1'b1, 4);
        check("basic_phase1", byte_phase, 1);
        byte_in = 8'h12; byte_sync = 1'b0;
        repeat (3) @(negedge clk);
        byte_strobe = 1'b1;
        repeat (3) @(negedge clk);
        check("basic_lat_valid0", sample_valid, 0);
        @(negedge clk);
        check("basic_valid", sample_valid, 1);
        check("basic_data", sample_data, 16'h1234);
        check("basic_level1", fifo_level, 1);
        check("basic_phase0", byte_phase, 0);
        @(negedge clk);
        check("basic_popped", sample_valid, 0);
        check("basic_level0", fifo_level, 0);
        byte_strobe = 1'b0;
        repeat (3) @(negedge clk);
        sample_ready = 1'b0;

        // Resync discards the partial word without flagging overflow.
        send_byte(8'hAA, 1'b1, 4);
        send_byte(8'h55, 1'b1, 4);
        check("resync_phase", byte_phase, 1);
        check("resync_nopush", fifo_level, 0);
        send_byte(8'h80, 1'b0, 4);
        check("resync_level", fifo_level, 1);
        check("resync_data", sample_data, 16'h8055);
        check("resync_ovf", overflow, 0);
        pop_one();
        check("resync_drained", fifo_level, 0);

        // Backpressure: fifth word is dropped and overflow sticks.
        for (int i = 1; i <= 5; i++) send_word(16'(i));
        check("bp_level", fifo_level, 4);
        check("bp_ovf", overflow, 1);
        for (int i = 1; i <= 4; i++) begin
            check("bp_drain_valid", sample_valid, 1);
            check("bp_drain_data", sample_data, i);
            pop_one();
        end
        check("bp_empty", sample_valid, 0);
        check("bp_ovf_sticky", overflow, 1);
        clr_ovf = 1'b1;
        @(negedge clk);
        clr_ovf = 1'b0;
        check("bp_ovf_clr", overflow, 0);

        // Full FIFO with a pop on the push edge accepts the new word.
        for (int i = 5; i <= 8; i++) send_word(16'(i));
        check("fp_level_full", fifo_level, 4);
        send_byte(8'h09, 1'b1, 4);
        byte_in = 8'h00; byte_sync = 1'b0;
        repeat (3) @(negedge clk);
        byte_strobe = 1'b1;
        repeat (3) @(negedge clk);
        sample_ready = 1'b1;
        @(negedge clk);
        sample_ready = 1'b0;
        check("fp_level", fifo_level, 4);
        check("fp_ovf", overflow, 0);
        byte_strobe = 1'b0;
        repeat (3) @(negedge clk);
        for (int i = 6; i <= 9; i++) begin
            check("fp_drain_data", sample_data, i);
            pop_one();
        end
        check("fp_empty", fifo_level, 0);

        // Reset mid-word discards the captured LSB byte.
        send_byte(8'h77, 1'b1, 4);
        check("mr_phase1", byte_phase, 1);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check("mr_phase0", byte_phase, 0);
        send_byte(8'hBB, 1'b0, 4);
        send_byte(8'hCC, 1'b0, 4);
        check("mr_level", fifo_level, 1);
        check("mr_data", sample_data, 16'hCCBB);
        pop_one();

        // A strobe held high for 20 cycles captures exactly once.
        send_byte(8'h42, 1'b0, 20);
        check("long_phase", byte_phase, 1);
        check("long_level", fifo_level, 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
